// File: rtl/id_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : id_stage_pipe
// Purpose  : ARM-subset decode with register file, bypass and ID/EX register
// Revision : 1.0
// ============================================================================
module id_stage_pipe #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 15,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       instruction,
   input  logic [DATA_W-1:0] PC_in,
   input  logic              in_valid,
   input  logic [3:0]        StatusRegister_input,
   input  logic              hazard,
   input  logic              flush,
   input  logic              WB_WB_EN,
   input  logic [3:0]        WB_Dest,
   input  logic [DATA_W-1:0] WB_Value,
   output logic [3:0]        src1,
   output logic [3:0]        src2,
   output logic              Two_src,
   output logic              id_stall,
   output logic              ex_valid,
   output logic [3:0]        EXE_CMD,
   output logic              MEM_R_EN,
   output logic              MEM_W_EN,
   output logic              WB_EN,
   output logic              S,
   output logic              B,
   output logic [DATA_W-1:0] Val_Rn,
   output logic [DATA_W-1:0] Val_Rm,
   output logic [3:0]        Dest,
   output logic [23:0]       Signed_imm_24,
   output logic [11:0]       Shift_operand,
   output logic              imm,
   output logic [DATA_W-1:0] PC_out,
   output logic [3:0]        StatusRegister_output
);

   localparam logic [1:0] c_MODE_DATA = 2'b00;
   localparam logic [1:0] c_MODE_MEM  = 2'b01;
   localparam logic [1:0] c_MODE_BR   = 2'b10;
   localparam logic [4:0] c_NREGS     = 5'(NUM_REGS);
   localparam bit         c_BYP       = (BYPASS != 0);

   logic [3:0] w_cond, w_op, w_rd, w_rm;
   logic [1:0] w_mode;
   logic       w_i, w_s_in;
   logic       w_n, w_z, w_c, w_v;

   assign w_cond = instruction[31:28];
   assign w_mode = instruction[27:26];
   assign w_i    = instruction[25];
   assign w_op   = instruction[24:21];
   assign w_s_in = instruction[20];
   assign w_rd   = instruction[15:12];
   assign w_rm   = instruction[3:0];
   assign {w_n, w_z, w_c, w_v} = StatusRegister_input;

   logic [3:0] w_cmd;
   logic       w_mr, w_mw, w_wb, w_s, w_b;

   always_comb begin
      w_cmd = 4'b0000;
      w_mr  = 1'b0;
      w_mw  = 1'b0;
      w_wb  = 1'b0;
      w_s   = 1'b0;
      w_b   = 1'b0;
      case (w_mode)
         c_MODE_DATA: begin
            w_wb = 1'b1;
            w_s  = w_s_in;
            case (w_op)
               4'b1101: w_cmd = 4'b0001;
               4'b1111: w_cmd = 4'b1001;
               4'b0100: w_cmd = 4'b0010;
               4'b0101: w_cmd = 4'b0011;
               4'b0010: w_cmd = 4'b0100;
               4'b0110: w_cmd = 4'b0101;
               4'b0000: w_cmd = 4'b0110;
               4'b1100: w_cmd = 4'b0111;
               4'b0001: w_cmd = 4'b1000;
               // compare/test only set flags, never write a register
               4'b1010: begin w_cmd = 4'b0100; w_wb = 1'b0; w_s = 1'b1; end
               4'b1000: begin w_cmd = 4'b0110; w_wb = 1'b0; w_s = 1'b1; end
               default: begin w_wb = 1'b0; w_s = 1'b0; end
            endcase
         end
         c_MODE_MEM: begin
            w_cmd = 4'b0010;
            w_mr  = w_s_in;
            w_wb  = w_s_in;
            w_mw  = ~w_s_in;
         end
         c_MODE_BR: w_b = 1'b1;
         default: ;
      endcase
   end

   logic w_cond_pass;

   always_comb begin
      case (w_cond)
         4'h0:    w_cond_pass = w_z;
         4'h1:    w_cond_pass = ~w_z;
         4'h2:    w_cond_pass = w_c;
         4'h3:    w_cond_pass = ~w_c;
         4'h4:    w_cond_pass = w_n;
         4'h5:    w_cond_pass = ~w_n;
         4'h6:    w_cond_pass = w_v;
         4'h7:    w_cond_pass = ~w_v;
         4'h8:    w_cond_pass = w_c & ~w_z;
         4'h9:    w_cond_pass = ~w_c | w_z;
         4'hA:    w_cond_pass = (w_n == w_v);
         4'hB:    w_cond_pass = (w_n != w_v);
         4'hC:    w_cond_pass = ~w_z & (w_n == w_v);
         4'hD:    w_cond_pass = w_z | (w_n != w_v);
         4'hE:    w_cond_pass = 1'b1;
         default: w_cond_pass = 1'b0;
      endcase
   end

   assign src1     = instruction[19:16];
   assign src2     = w_mw ? w_rd : w_rm;
   assign Two_src  = ~w_i | w_mw;
   assign id_stall = hazard & ~flush;

   // Register file
   logic [DATA_W-1:0] regs_q  [NUM_REGS];
   logic [DATA_W-1:0] regs_d  [NUM_REGS];
   logic [DATA_W-1:0] rf_view [16];

   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_d[i] = (WB_WB_EN && (WB_Dest == 4'(i))) ? WB_Value : regs_q[i];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= DATA_W'(i);
      end else begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      end
   end

   // Full 16-entry view so a 4-bit index never leaves the array
   for (genvar gi = 0; gi < 16; gi++) begin : g_view
      if (gi < NUM_REGS) begin : g_impl
         assign rf_view[gi] = regs_q[gi];
      end else begin : g_none
         assign rf_view[gi] = '0;
      end
   end

   logic              w_ok1, w_ok2, w_byp1, w_byp2;
   logic [DATA_W-1:0] w_rd1, w_rd2;

   assign w_ok1  = ({1'b0, src1} < c_NREGS);
   assign w_ok2  = ({1'b0, src2} < c_NREGS);
   assign w_byp1 = c_BYP && WB_WB_EN && (WB_Dest == src1);
   assign w_byp2 = c_BYP && WB_WB_EN && (WB_Dest == src2);
   assign w_rd1  = !w_ok1 ? '0 : (w_byp1 ? WB_Value : rf_view[src1]);
   assign w_rd2  = !w_ok2 ? '0 : (w_byp2 ? WB_Value : rf_view[src2]);

   // ID/EX register: controls are squashed to a bubble, data always loads
   logic              w_live;
   logic [9:0]        ctrl_d, ctrl_q;
   logic [DATA_W-1:0] val_rn_d, val_rn_q, val_rm_d, val_rm_q, pc_d, pc_q;
   logic [3:0]        dest_d, dest_q, sr_d, sr_q;
   logic [23:0]       simm_d, simm_q;
   logic [11:0]       shop_d, shop_q;
   logic              imm_d, imm_q;

   assign w_live = in_valid & w_cond_pass & ~hazard & ~flush;

   always_comb begin
      ctrl_d   = {1'b1, w_cmd, w_mr, w_mw, w_wb, w_s, w_b} & {10{w_live}};
      val_rn_d = w_rd1;
      val_rm_d = w_rd2;
      dest_d   = w_rd;
      simm_d   = instruction[23:0];
      shop_d   = instruction[11:0];
      imm_d    = w_i;
      pc_d     = PC_in;
      sr_d     = StatusRegister_input;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctrl_q   <= '0;
         val_rn_q <= '0;
         val_rm_q <= '0;
         dest_q   <= '0;
         simm_q   <= '0;
         shop_q   <= '0;
         imm_q    <= 1'b0;
         pc_q     <= '0;
         sr_q     <= '0;
      end else begin
         ctrl_q   <= ctrl_d;
         val_rn_q <= val_rn_d;
         val_rm_q <= val_rm_d;
         dest_q   <= dest_d;
         simm_q   <= simm_d;
         shop_q   <= shop_d;
         imm_q    <= imm_d;
         pc_q     <= pc_d;
         sr_q     <= sr_d;
      end
   end

   assign {ex_valid, EXE_CMD, MEM_R_EN, MEM_W_EN, WB_EN, S, B} = ctrl_q;
   assign Val_Rn                = val_rn_q;
   assign Val_Rm                = val_rm_q;
   assign Dest                  = dest_q;
   assign Signed_imm_24         = simm_q;
   assign Shift_operand         = shop_q;
   assign imm                   = imm_q;
   assign PC_out                = pc_q;
   assign StatusRegister_output = sr_q;

endmodule
`default_nettype wire

// File: tb/tb_id_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_stage_pipe
// Purpose  : Random + directed bench for id_stage_pipe (three parameter sets)
// Revision : 1.0
// ============================================================================
module tb_id_stage_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instruction, PC_in, WB_Value;
   logic        in_valid, hazard, flush, WB_WB_EN;
   logic [3:0]  StatusRegister_input, WB_Dest;

   logic [3:0]  src1_o[3], src2_o[3], cmd_o[3], dest_o[3], sro_o[3];
   logic        two_o[3], stall_o[3], exv_o[3], mr_o[3], mw_o[3], wb_o[3];
   logic        s_o[3], b_o[3], imm_o[3];
   logic [31:0] vrn_o[3], vrm_o[3], pc_o[3];
   logic [23:0] simm_o[3];
   logic [11:0] shop_o[3];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   // instance 0: default, 1: no bypass, 2: eight registers
   for (genvar k = 0; k < 3; k++) begin : g_dut
      id_stage_pipe #(
         .DATA_W   (32),
         .NUM_REGS ((k == 2) ? 8 : 15),
         .BYPASS   ((k == 1) ? 0 : 1)
      ) u_dut (
         .clk                   (clk),
         .rst                   (rst),
         .instruction           (instruction),
         .PC_in                 (PC_in),
         .in_valid              (in_valid),
         .StatusRegister_input  (StatusRegister_input),
         .hazard                (hazard),
         .flush                 (flush),
         .WB_WB_EN              (WB_WB_EN),
         .WB_Dest               (WB_Dest),
         .WB_Value              (WB_Value),
         .src1                  (src1_o[k]),
         .src2                  (src2_o[k]),
         .Two_src               (two_o[k]),
         .id_stall              (stall_o[k]),
         .ex_valid              (exv_o[k]),
         .EXE_CMD               (cmd_o[k]),
         .MEM_R_EN              (mr_o[k]),
         .MEM_W_EN              (mw_o[k]),
         .WB_EN                 (wb_o[k]),
         .S                     (s_o[k]),
         .B                     (b_o[k]),
         .Val_Rn                (vrn_o[k]),
         .Val_Rm                (vrm_o[k]),
         .Dest                  (dest_o[k]),
         .Signed_imm_24         (simm_o[k]),
         .Shift_operand         (shop_o[k]),
         .imm                   (imm_o[k]),
         .PC_out                (pc_o[k]),
         .StatusRegister_output (sro_o[k])
      );
   end

   typedef struct packed {
      logic        exv;
      logic [8:0]  ctrl;   // {cmd[3:0], mr, mw, wb, s, b}
      logic [31:0] rn, rm;
      logic [3:0]  dest;
      logic [23:0] simm;
      logic [11:0] shop;
      logic        imm;
      logic [31:0] pc;
      logic [3:0]  sr;
   } ex_t;

   logic [31:0] mrf [3][16];

   task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int nregs(input int k);
      return (k == 2) ? 8 : 15;
   endfunction

   function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
      bit n = f[3], z = f[2], cy = f[1], v = f[0];
      case (c)
         4'd0: return z;          4'd1: return !z;
         4'd2: return cy;         4'd3: return !cy;
         4'd4: return n;          4'd5: return !n;
         4'd6: return v;          4'd7: return !v;
         4'd8: return cy && !z;   4'd9: return !cy || z;
         4'd10: return n == v;    4'd11: return n != v;
         4'd12: return !z && (n == v);
         4'd13: return z || (n != v);
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [8:0] model_ctrl(input logic [31:0] ins);
      logic sb = ins[20];
      case (ins[27:26])
         2'b00: case (ins[24:21])
            4'hD: return {4'h1, 3'b001, sb, 1'b0};
            4'hF: return {4'h9, 3'b001, sb, 1'b0};
            4'h4: return {4'h2, 3'b001, sb, 1'b0};
            4'h5: return {4'h3, 3'b001, sb, 1'b0};
            4'h2: return {4'h4, 3'b001, sb, 1'b0};
            4'h6: return {4'h5, 3'b001, sb, 1'b0};
            4'h0: return {4'h6, 3'b001, sb, 1'b0};
            4'hC: return {4'h7, 3'b001, sb, 1'b0};
            4'h1: return {4'h8, 3'b001, sb, 1'b0};
            4'hA: return {4'h4, 5'b00010};
            4'h8: return {4'h6, 5'b00010};
            default: return 9'd0;
         endcase
         2'b01:   return sb ? {4'h2, 5'b10100} : {4'h2, 5'b01000};
         2'b10:   return 9'b0_0000_0001;
         default: return 9'd0;
      endcase
   endfunction

   function automatic logic [31:0] rdm(input int k, input logic [3:0] idx);
      if (int'(idx) >= nregs(k)) return 32'd0;
      if (k != 1 && WB_WB_EN && WB_Dest == idx) return WB_Value;
      return mrf[k][idx];
   endfunction

   // single compare process: combinational outputs before the edge, ID/EX after it
   initial begin
      ex_t exp_q [3];
      ex_t act;
      logic [8:0] c;
      logic [3:0] s2;
      forever begin
         @(negedge clk);
         #4;
         c  = model_ctrl(instruction);
         s2 = c[3] ? instruction[15:12] : instruction[3:0];
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("comb_k%0d", k),
                160'({src1_o[k], src2_o[k], two_o[k], stall_o[k]}),
                160'({instruction[19:16], s2, !instruction[25] || c[3], hazard && !flush}));
            if (!rst) begin
               exp_q[k] = '0;
               for (int r = 0; r < 16; r++) mrf[k][r] = 32'(r);
            end else begin
               exp_q[k].exv  = in_valid && cond_ok(instruction[31:28], StatusRegister_input)
                               && !hazard && !flush;
               exp_q[k].ctrl = exp_q[k].exv ? c : 9'd0;
               exp_q[k].rn   = rdm(k, instruction[19:16]);
               exp_q[k].rm   = rdm(k, s2);
               exp_q[k].dest = instruction[15:12];
               exp_q[k].simm = instruction[23:0];
               exp_q[k].shop = instruction[11:0];
               exp_q[k].imm  = instruction[25];
               exp_q[k].pc   = PC_in;
               exp_q[k].sr   = StatusRegister_input;
            end
         end
         if (rst && WB_WB_EN)
            for (int k = 0; k < 3; k++)
               if (int'(WB_Dest) < nregs(k)) mrf[k][WB_Dest] = WB_Value;
         @(posedge clk);
         #1;
         for (int k = 0; k < 3; k++) begin
            act = {exv_o[k], cmd_o[k], mr_o[k], mw_o[k], wb_o[k], s_o[k], b_o[k],
                   vrn_o[k], vrm_o[k], dest_o[k], simm_o[k], shop_o[k], imm_o[k],
                   pc_o[k], sro_o[k]};
            chk($sformatf("idex_k%0d", k), 160'(act), 160'(exp_q[k]));
         end
      end
   end

   task automatic drive(input logic [31:0] ins, input logic [3:0] fl, input logic hz, fs,
                        input logic we, input logic [3:0] wd, input logic [31:0] wv);
      @(negedge clk);
      instruction = ins; StatusRegister_input = fl; hazard = hz; flush = fs;
      in_valid = 1'b1; WB_WB_EN = we; WB_Dest = wd; WB_Value = wv; PC_in = PC_in + 32'd4;
      #1;
   endtask

   task automatic after_edge();
      @(posedge clk);
      #2;
   endtask

   task automatic rand_drive();
      logic [31:0] ins = $urandom;
      if ($urandom_range(0, 3) != 0) ins[31:28] = 4'hE;
      ins[27:26] = ($urandom_range(0, 9) < 6) ? 2'b00 : 2'($urandom_range(1, 3));
      @(negedge clk);
      instruction = ins;
      StatusRegister_input = 4'($urandom);
      hazard   = ($urandom_range(0, 4) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      in_valid = ($urandom_range(0, 9) != 0);
      WB_WB_EN = ($urandom_range(0, 1) == 1);
      WB_Dest  = 4'($urandom);
      WB_Value = $urandom;
      PC_in    = $urandom;
   endtask

   initial begin
      rst = 1'b0; instruction = '0; PC_in = '0; in_valid = 1'b0; hazard = 1'b0;
      flush = 1'b0; WB_WB_EN = 1'b0; WB_Dest = '0; WB_Value = '0;
      StatusRegister_input = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_exv", 160'(exv_o[0]), 160'd0);
      chk("reset_pc", 160'(pc_o[0]), 160'd0);
      rst = 1'b1;

      drive(32'hE1A01002, 4'h0, 0, 0, 0, 4'd0, 32'd0);
      after_edge();
      chk("mov_valrm", 160'(vrm_o[0]), 160'd2);
      chk("mov_cmd",   160'(cmd_o[0]), 160'd1);
      chk("mov_wb",    160'(wb_o[0]),  160'd1);
      chk("mov_dest",  160'(dest_o[0]), 160'd1);

      drive(32'h00821003, 4'b0100, 0, 0, 0, 4'd0, 32'd0);
      after_edge();
      chk("addeq_exv", 160'(exv_o[0]), 160'd1);
      chk("addeq_cmd", 160'(cmd_o[0]), 160'd2);
      drive(32'h00821003, 4'b0000, 0, 0, 0, 4'd0, 32'd0);
      after_edge();
      chk("addeq_fail_exv", 160'(exv_o[0]), 160'd0);

      drive(32'hE0423004, 4'h0, 0, 0, 1, 4'd2, 32'hDEAD);
      after_edge();
      chk("bypass_on_rn",  160'(vrn_o[0]), 160'hDEAD);
      chk("bypass_off_rn", 160'(vrn_o[1]), 160'd2);

      for (int h = 0; h < 2; h++) begin
         drive(32'hE0423004, 4'h0, 1, 0, 0, 4'd0, 32'd0);
         chk("hazard_stall", 160'(stall_o[0]), 160'd1);
         after_edge();
         chk("hazard_bubble", 160'(exv_o[0]), 160'd0);
      end
      drive(32'hE0423004, 4'h0, 0, 0, 0, 4'd0, 32'd0);
      after_edge();
      chk("hazard_issue_exv", 160'(exv_o[0]), 160'd1);
      chk("hazard_issue_cmd", 160'(cmd_o[0]), 160'd4);
      chk("stored_rn_nobyp",  160'(vrn_o[1]), 160'hDEAD);
      drive(32'hE0423004, 4'h0, 1, 1, 0, 4'd0, 32'd0);
      chk("flush_nostall", 160'(stall_o[0]), 160'd0);
      after_edge();
      chk("flush_bubble", 160'(exv_o[0]), 160'd0);

      drive(32'hE5815000, 4'h0, 0, 0, 0, 4'd0, 32'd0);
      chk("str_two_src", 160'(two_o[0]), 160'd1);
      chk("str_src2",    160'(src2_o[0]), 160'd5);
      after_edge();
      chk("str_memw",  160'(mw_o[0]), 160'd1);
      chk("str_valrm", 160'(vrm_o[0]), 160'd5);
      drive(32'hE5915000, 4'h0, 0, 0, 0, 4'd0, 32'd0);
      after_edge();
      chk("ldr_memr_wb", 160'({mr_o[0], wb_o[0]}), 160'd3);

      drive(32'hE1A0000C, 4'h0, 0, 0, 1, 4'd12, 32'h1234);
      after_edge();
      chk("oor_read_n8",  160'(vrm_o[2]), 160'd0);
      chk("oor_bypass15", 160'(vrm_o[0]), 160'h1234);
      drive(32'hE1A0000C, 4'h0, 0, 0, 0, 4'd0, 32'd0);
      after_edge();
      chk("oor_stored_n8", 160'(vrm_o[2]), 160'd0);
      chk("oor_stored15",  160'(vrm_o[0]), 160'h1234);

      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            @(negedge clk); rst = 1'b0;
            @(negedge clk); rst = 1'b1;
         end
         rand_drive();
      end

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
